latch_out_sampler: RTL and testbench
====================================

Name: latch_out_sampler

Overview:
- Downstream consumer of the level-sensitive D latch output `q`.
- Brings `q` into the `clk` domain through a synchroniser, then debounces it against glitches from transparent-phase changes.
- Reports each qualified level change as an event on a valid/ready handshake and keeps a saturating transition counter.
- Sits between the latch stage and any clocked logic that reacts to latched data.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range 2-4).
- STABLE_CYCLES, 4, consecutive synchronised samples that must differ from the current stable level before that level changes (legal range ≥1).
- CNT_W, 8, width of the transition counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- q_in  in  1  latch output `q`; asynchronous to `clk`.
- cnt_clr  in  1  synchronous clear of `trans_count` and `overrun`.
- q_stable  out  1  debounced, synchronised level.
- evt_valid  out  1  a level-change event is pending.
- evt_ready  in  1  consumer accepts the event.
- evt_level  out  1  new level carried by the pending event.
- trans_count  out  CNT_W  number of qualified transitions, saturating.
- overrun  out  1  sticky; set when an event was overwritten before being accepted.

Behaviour:
- Reset (async, active-high) forces immediately:
  - synchroniser flops = 0, `q_stable` = 0, debounce count = 0, state = IDLE;
  - `evt_valid` = 0, `evt_level` = 0, `trans_count` = 0, `overrun` = 0.
- Reset asserted mid-qualification or with an event pending drops everything. No event is produced after release until a fresh qualified change occurs.
- Synchroniser: shift chain of SYNC_STAGES flops. The last flop output `s` is the only value used downstream.
- Debounce FSM, two states:
  - IDLE: `s == q_stable`, debounce count held at 0. If `s != q_stable`, go to QUAL and set count to 1.
  - QUAL, with `s != q_stable`:
    - if count == STABLE_CYCLES-1, set `q_stable <= s`, clear count, go to IDLE, fire a change;
    - otherwise increment count.
  - QUAL, with `s == q_stable`: clear count, go to IDLE (glitch rejected, no event).
  - STABLE_CYCLES = 1: the change fires directly from IDLE on the first differing sample. QUAL is never entered.
- Latency: a step on `q_in` sampled at rising edge 1 updates `q_stable` at edge SYNC_STAGES+STABLE_CYCLES (edge 6 at defaults).
  - Any `q_in` pulse shorter than STABLE_CYCLES clock periods at `s` produces no change.
- Event handshake, on a fired change:
  - `evt_valid <= 1`, `evt_level <= new q_stable`.
  - Transfer completes when `evt_valid && evt_ready` at a rising edge; `evt_valid` then clears unless a new change fires in that same cycle.
  - `evt_valid` and `evt_level` stay stable while `evt_ready` is low, except on overrun.
- Overrun:
  - A change fires while `evt_valid=1` and `evt_ready=0`: `evt_level` is overwritten with the newest level, `evt_valid` stays 1, `overrun <= 1`.
  - A change fires in the same cycle as an accepting handshake: the new event is loaded, `evt_valid` stays 1, no overrun.
- trans_count:
  - Increments by 1 on every fired change; saturates at 2^CNT_W-1 with no wrap.
  - `cnt_clr` clears `trans_count` and `overrun`. If a change fires in the same cycle, clear wins (count = 0, and `overrun` = 0 even if an overwrite occurs that cycle).
  - `cnt_clr` does not affect the event handshake.
- Every output is registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package `latch_pkg`:
  - FSM state enum {IDLE, QUAL};
  - default constants SYNC_STAGES_DEF=2, STABLE_CYCLES_DEF=4, CNT_W_DEF=8.
- One sub-module `bit_sync`: parameterised SYNC_STAGES flop chain with async active-high reset to 0. It is reusable by other blocks that cross latch outputs into `clk`.
- FSM, handshake and counter live in the top module.

Test Plan:
- Reset check:
  - Stimulus: assert `rst` mid-cycle with `q_in`=1.
  - Required response: all outputs 0 immediately, without waiting for a clk edge; after release with `q_in` held at 1, `q_stable`=1 at edge 6, `evt_valid`=1, `evt_level`=1, `trans_count`=1.
- Glitch rejection:
  - Stimulus: `q_in` 0→1 for 3 clk periods then back to 0 (defaults).
  - Required response: `q_stable` stays 0, `evt_valid` stays 0, `trans_count`=0.
- Two events with handshake:
  - Stimulus: `evt_ready`=1; `q_in` 0→1, hold 10 cycles, then 1→0.
  - Required response: two single-cycle `evt_valid` pulses with `evt_level` 1 then 0; `trans_count`=2; `overrun`=0.
- Overrun:
  - Stimulus: `evt_ready`=0; `q_in` 0→1, held 10 cycles, then →0.
  - Required response: `evt_valid` stays 1 with `evt_level`=0; `overrun`=1; `trans_count`=2. Raising `evt_ready` for 1 cycle clears `evt_valid`.
- Saturation and clear:
  - Stimulus: CNT_W=2, toggle `q_in` 5 times with full qualification.
  - Required response: `trans_count` stops at 3. Pulse `cnt_clr` in the same cycle as a fired change: `trans_count`=0, `overrun`=0.
- Boundary parameters:
  - Stimulus: STABLE_CYCLES=1, SYNC_STAGES=3; step `q_in` to 1.
  - Required response: `q_stable`=1 at edge 4; a 1-cycle pulse at `s` is accepted as a change.

Source files
------------

// File: rtl/latch_pkg.sv
// latch_pkg: shared types and default constants for latch-output consumers.
package latch_pkg;
    typedef enum logic {IDLE, QUAL} state_t;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: multi-flop synchroniser bringing an asynchronous bit into clk.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk or posedge rst)
        if (rst) chain <= '0;
        else chain <= {chain[SYNC_STAGES-2:0], d};
    assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/latch_out_sampler.sv
// latch_out_sampler: synchronises and debounces latch output q, reports level
// changes on a valid/ready handshake and counts them with saturation.
module latch_out_sampler
    import latch_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             cnt_clr,
    output logic             q_stable,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_level,
    output logic [CNT_W-1:0] trans_count,
    output logic             overrun
);
    localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    logic s, fire;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d(q_in),
        .q(s)
    );
    // A single-sample qualification window skips QUAL and fires from IDLE.
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        fire = 1'b0;
        if (s == q_stable) begin
            state_nx = IDLE;
            cnt_nx = '0;
        end else if (state == IDLE && STABLE_CYCLES > 1) begin
            state_nx = QUAL;
            cnt_nx = CW'(1);
        end else if (state == IDLE || cnt == LAST) begin
            fire = 1'b1;
            state_nx = IDLE;
            cnt_nx = '0;
        end else begin
            cnt_nx = cnt + CW'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            q_stable <= 1'b0;
            evt_valid <= 1'b0;
            evt_level <= 1'b0;
            trans_count <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (fire) q_stable <= s;
            if (fire) begin
                evt_valid <= 1'b1;
                evt_level <= s;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
            // Clear dominates both the count and any overwrite in the same cycle.
            if (cnt_clr) overrun <= 1'b0;
            else if (fire && evt_valid && !evt_ready) overrun <= 1'b1;
            if (cnt_clr) trans_count <= '0;
            else if (fire && !(&trans_count)) trans_count <= trans_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_latch_out_sampler.sv
// tb_latch_out_sampler: directed checks on default, narrow-counter and
// fast-qualification instances driven by shared stimulus.
module tb_latch_out_sampler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q_in = 1'b0;
    logic cnt_clr = 1'b0;
    logic evt_ready = 1'b0;
    logic a_qs, a_v, a_l, a_ov, b_qs, b_v, b_l, b_ov, c_qs, c_v, c_l, c_ov;
    logic [7:0] a_cnt, c_cnt;
    logic [1:0] b_cnt;
    int errors = 0;
    int checks = 0;
    int vcnt;
    logic vlev;

    always #5 clk = ~clk;

    latch_out_sampler u_a (
        .clk(clk), .rst(rst), .q_in(q_in), .cnt_clr(cnt_clr), .q_stable(a_qs),
        .evt_valid(a_v), .evt_ready(evt_ready), .evt_level(a_l),
        .trans_count(a_cnt), .overrun(a_ov)
    );
    latch_out_sampler #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .q_in(q_in), .cnt_clr(cnt_clr), .q_stable(b_qs),
        .evt_valid(b_v), .evt_ready(evt_ready), .evt_level(b_l),
        .trans_count(b_cnt), .overrun(b_ov)
    );
    latch_out_sampler #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) u_c (
        .clk(clk), .rst(rst), .q_in(q_in), .cnt_clr(cnt_clr), .q_stable(c_qs),
        .evt_valid(c_v), .evt_ready(evt_ready), .evt_level(c_l),
        .trans_count(c_cnt), .overrun(c_ov)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        q_in = 1'b0;
        evt_ready = 1'b0;
        cnt_clr = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic watch(input int n);
        vcnt = 0;
        vlev = 1'b0;
        repeat (n) begin
            tick();
            if (a_v) begin
                vcnt++;
                vlev = a_l;
            end
        end
    endtask

    initial begin
        do_reset();
        tick(2);
        chk("reset_qs", a_qs, 0);
        chk("reset_cnt", a_cnt, 0);

        // async reset with a fired event outstanding
        q_in = 1'b1;
        tick(8);
        chk("pre_rst_valid", a_v, 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_outs", {a_qs, a_v, a_l, a_ov, a_cnt}, 0);
        tick();
        rst = 1'b0;
        tick(3);
        chk("c_qs_edge3", c_qs, 0);
        tick();
        chk("c_qs_edge4", c_qs, 1);
        tick();
        chk("a_qs_edge5", a_qs, 0);
        chk("a_valid_edge5", a_v, 0);
        tick();
        chk("a_qs_edge6", a_qs, 1);
        chk("a_valid_edge6", a_v, 1);
        chk("a_level_edge6", a_l, 1);
        chk("a_cnt_edge6", a_cnt, 1);

        // glitch of 3 periods rejected by default instance
        do_reset();
        tick();
        q_in = 1'b1;
        tick(3);
        q_in = 1'b0;
        tick(10);
        chk("glitch_qs", a_qs, 0);
        chk("glitch_valid", a_v, 0);
        chk("glitch_cnt", a_cnt, 0);
        chk("glitch_c_cnt", c_cnt, 2);
        q_in = 1'b1;
        tick();
        q_in = 1'b0;
        tick(8);
        chk("pulse1_c_cnt", c_cnt, 4);
        chk("pulse1_c_qs", c_qs, 0);
        chk("pulse1_a_cnt", a_cnt, 0);

        // two events with ready held high
        do_reset();
        tick();
        evt_ready = 1'b1;
        q_in = 1'b1;
        watch(10);
        chk("hs1_pulses", vcnt, 1);
        chk("hs1_level", vlev, 1);
        q_in = 1'b0;
        watch(10);
        chk("hs2_pulses", vcnt, 1);
        chk("hs2_level", vlev, 0);
        chk("hs_cnt", a_cnt, 2);
        chk("hs_overrun", a_ov, 0);

        // overrun with ready held low
        do_reset();
        tick();
        q_in = 1'b1;
        tick(10);
        chk("ov_first_valid", a_v, 1);
        chk("ov_first_level", a_l, 1);
        chk("ov_first_flag", a_ov, 0);
        q_in = 1'b0;
        tick(10);
        chk("ov_valid", a_v, 1);
        chk("ov_level", a_l, 0);
        chk("ov_flag", a_ov, 1);
        chk("ov_cnt", a_cnt, 2);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("ov_accept_valid", a_v, 0);
        chk("ov_sticky", a_ov, 1);

        // saturation on the 2-bit counter, then clear racing a fired change
        do_reset();
        tick();
        evt_ready = 1'b1;
        repeat (5) begin
            q_in = ~q_in;
            tick(8);
        end
        chk("sat_b_cnt", b_cnt, 3);
        chk("sat_a_cnt", a_cnt, 5);
        evt_ready = 1'b0;
        repeat (2) begin
            q_in = ~q_in;
            tick(8);
        end
        chk("sat_b_overrun", b_ov, 1);
        q_in = ~q_in;
        tick(5);
        chk("clr_pre_qs", b_qs, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_qs", b_qs, 0);
        chk("clr_cnt", b_cnt, 0);
        chk("clr_overrun", b_ov, 0);
        chk("clr_valid", b_v, 1);
        chk("clr_level", b_l, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
